// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V controller and its datapath.
// MC_CTRL_ILLEGAL_TRAP_EN adds the StTrap state to the state enum.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StLui
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    StTrap
`endif
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  localparam logic AdrPc     = 1'b0;
  localparam logic AdrResult = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's alu_op plus instruction function fields to an ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    unique case (alu_op)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        unique case (funct3)
          // Only R-type (op[5]=1) uses funct7b5 to select sub; addi ignores it.
          3'b000:  alu_control = (funct7b5 & op5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: Moore FSM sequencing the shared datapath plus opcode decode.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky StTrap state.
module mc_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write_s, reg_write_s, mem_write_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StLui:      state_d = StAluWb;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    alu_src_a   = SrcAPc;
    alu_src_b   = SrcBRs2;
    result_src  = ResAluOut;
    adr_src     = AdrPc;
    alu_op      = AluOpAdd;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    unique case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAlu;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: adr_src = AdrResult;
      StMemWb: begin
        result_src  = ResMem;
        reg_write_s = 1'b1;
      end
      StMemWrite: begin
        adr_src     = AdrResult;
        mem_write_s = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write_s = 1'b1;
      StBeq: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
      end
      StLui: begin
        alu_src_a = SrcAZero;
        alu_src_b = SrcBImm;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (op)
      OpStore: imm_src = ImmS;
      OpBeq:   imm_src = ImmB;
      OpJal:   imm_src = ImmJ;
      OpLui:   imm_src = ImmU;
      default: imm_src = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  // Strobes are gated by rst_n so nothing writes during the asynchronous reset window.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign mem_write = rst_n & mem_write_s;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = rst_n & (state_q == StTrap);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; follows MC_CTRL_ILLEGAL_TRAP_EN if defined.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       adr_src, pc_write, ir_write, reg_write, mem_write, illegal_instr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .imm_src       (imm_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .result_src    (result_src),
    .adr_src       (adr_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .illegal_instr (illegal_instr)
  );

  // Field order: imm, a, b, alu_control, result_src, adr_src, pc_write, ir_write, reg_write, mem_write
  function automatic logic [16:0] o(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] aluc, input logic [1:0] rs, input logic adr,
                                    input logic pcw, input logic irw, input logic rw,
                                    input logic mw);
    return {imm, a, b, aluc, rs, adr, pcw, irw, rw, mw};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    #1;
    obs = {imm_src, alu_src_a, alu_src_b, alu_control, result_src, adr_src,
           pc_write, ir_write, reg_write, mem_write};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ill(input string tag, input logic exp);
    n_cmp++;
    assert (illegal_instr === exp) else begin
      n_err++;
      $error("FAIL %s: illegal_instr observed %b, expected %b", tag, illegal_instr, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    chk("reset_fetch_gated", o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 0));
    chk_ill("reset_illegal", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw 0x00412083
    chk("lw_fetch", o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); chk("lw_decode", o(3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("lw_memadr", o(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("lw_memread", o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0));
    adv(); chk("lw_memwb", o(3'b000, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0, 1, 0));

    // sw 0x00112223, mem_ready low for two MEMWRITE cycles
    adv(); op = 7'b0100011; funct3 = 3'b010;
    chk("sw_fetch", o(3'b001, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); chk("sw_decode", o(3'b001, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("sw_memadr", o(3'b001, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); mem_ready = 1'b0;
    chk("sw_memwrite1", o(3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    adv(); chk("sw_memwrite2", o(3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    adv(); mem_ready = 1'b1;
    chk("sw_memwrite3", o(3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    adv(); chk("sw_back_fetch", o(3'b001, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));

    // Reset asserted mid-MEMWRITE
    adv(); adv(); adv(); mem_ready = 1'b0;
    chk("rst_pre_memwrite", o(3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    rst_n = 1'b0;
    chk("rst_mid_memwrite", o(3'b001, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    chk("rst_release_fetch", o(3'b010, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));

    // beq taken, then zero drops within the same BEQ cycle
    adv(); chk("beq_decode", o(3'b010, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("beq_taken", o(3'b010, 2'b10, 2'b00, 3'b001, 2'b00, 0, 1, 0, 0, 0));
    zero = 1'b0;
    chk("beq_zero_comb", o(3'b010, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("beq_fetch", o(3'b010, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); adv(); chk("beq_not_taken", o(3'b010, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));

    // sub 0x40208033
    adv(); op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    chk("sub_fetch", o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); adv(); chk("sub_execr", o(3'b000, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("sub_aluwb", o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));

    // addi with funct7b5=1 still adds
    adv(); op = 7'b0010011;
    adv(); adv(); chk("addi_execi", o(3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("addi_aluwb", o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));

    // slti and R-type or
    adv(); funct3 = 3'b010; funct7b5 = 1'b0;
    adv(); adv(); chk("slti_execi", o(3'b000, 2'b10, 2'b01, 3'b101, 2'b00, 0, 0, 0, 0, 0));
    adv(); adv(); op = 7'b0110011; funct3 = 3'b110;
    adv(); adv(); chk("or_execr", o(3'b000, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0, 0, 0, 0));

    // jal
    adv(); adv(); op = 7'b1101111;
    chk("jal_fetch", o(3'b011, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); adv(); chk("jal_jal", o(3'b011, 2'b01, 2'b10, 3'b000, 2'b00, 0, 1, 0, 0, 0));
    adv(); chk("jal_aluwb", o(3'b011, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));

    // lui
    adv(); op = 7'b0110111;
    adv(); adv(); chk("lui_lui", o(3'b100, 2'b11, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    adv(); chk("lui_aluwb", o(3'b100, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));

    // Unsupported opcode
    adv(); op = 7'b0000000;
    chk("ill_fetch", o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    adv(); chk("ill_decode", o(3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      adv();
      chk("trap_no_strobes", o(3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0));
      chk_ill("trap_illegal", 1'b1);
    end
    rst_n = 1'b0;
    #1 chk_ill("trap_reset_clears", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    adv(); chk("ill_nop_fetch", o(3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    chk_ill("ill_tied_zero", 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main controller for the RISC-V core. It sequences the shared datapath (immediate extender, ALU, register file, instruction register, unified memory) over several cycles per instruction. Each cycle it drives the extender's `imm_src`, the ALU operand muxes and function, and every write strobe. Supported instructions are lw, sw, R-type ALU, I-type ALU, beq, jal and lui. A `mem_ready` handshake stretches memory cycles.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_src_a` out 2: 00 PC, 01 old PC, 10 rs1, 11 constant zero.
- `alu_src_b` out 2: 00 rs2, 01 imm_ext, 10 constant 4.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `result_src` out 2: 00 ALU-out register, 01 memory data, 10 ALU result.
- `adr_src` out 1: 0 PC, 1 result.
- `pc_write`, `ir_write`, `reg_write`, `mem_write` out 1 each: write strobes.
- `illegal_instr` out 1: only with `MC_CTRL_ILLEGAL_TRAP_EN`; otherwise tied 0.

## Operation
- Moore FSM plus combinational decode.
- `imm_src` decodes from `op` in every state:
  - sw → 001; beq → 010; jal → 011; lui → 100.
  - Everything else → 000.
- `alu_op` is internal. 00 gives add, 01 gives sub. 10 decodes `funct3`:
  - 000: sub if `funct7b5 & op[5]`, else add.
  - 010: slt. 110: or. 111: and.
  - Any other value: add.
- Defaults in every state are all strobes 0, `alu_op` 00, and mux selects 00, unless the state lists otherwise.
- `pc_write = pc_update | (branch & zero)`.

States:
- FETCH: `adr_src`=0, a=00, b=10, `result_src`=10.
  - `ir_write` and `pc_update` = `mem_ready`.
  - Stay while `!mem_ready`; else go to DECODE.
- DECODE: a=01, b=01, computes the branch target. Next state by `op`:
  - lw/sw → MEMADR; R (0110011) → EXECUTER; I (0010011) → EXECUTEI.
  - beq → BEQ; jal → JAL; lui → LUI.
  - Any other opcode → FETCH (see Configuration).
- MEMADR: a=10, b=01. Go to MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: `adr_src`=1, `result_src`=00. Wait for `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00.
  - `mem_write`=1, held every cycle until `mem_ready`.
  - Then → FETCH.
- EXECUTER: a=10, b=00, `alu_op`=10 → ALUWB.
- EXECUTEI: a=10, b=01, `alu_op`=10 → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BEQ: a=10, b=00, `alu_op`=01, `result_src`=00, branch=1 → FETCH.
- JAL: a=01, b=10, `result_src`=00, `pc_update`=1 → ALUWB.
- LUI: a=11, b=01 → ALUWB.

## Timing
- Reset:
  - `rst_n` low forces state FETCH immediately and asynchronously.
  - While `rst_n` is low, the four strobes are gated to 0 and `illegal_instr` is 0.
  - Other outputs show FETCH values.
  - Reset mid-instruction abandons it; no partial write occurs after `rst_n` falls.
- Cycle counts with `mem_ready` constantly 1:
  - lw 5, sw 4, R/I 4, beq 3, jal 4, lui 4.
  - Each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- `pc_write` in BEQ depends combinationally on `zero` from the same cycle.
- Outputs are valid in the same cycle as the state. There are no registered outputs.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode in DECODE goes to TRAP.
  - In TRAP, all strobes are 0 and `illegal_instr`=1.
  - TRAP holds until reset.
- Undefined:
  - An unsupported opcode in DECODE returns to FETCH with no writes, i.e. it executes as a 2-cycle NOP.
  - `illegal_instr` is constant 0 and the TRAP state does not exist.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - `imm_src` encodings (shared with the immediate extender);
  - `alu_control` codes;
  - mux-select constants.
- Sub-module `alu_decoder`: combinational mapping of (`alu_op`, `funct3`, `funct7b5`, `op[5]`) to `alu_control`.

## Test plan
- Reset mid-MEMWRITE:
  - Stimulus: drop `rst_n` while `mem_write`=1.
  - Response: `mem_write` goes to 0 immediately. After release, the next edge with `mem_ready`=1 asserts `ir_write`=1 and `pc_write`=1.
- lw `0x00412083` with `mem_ready`=1:
  - Response: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `imm_src`=000; `reg_write`=1 only in cycle 5 with `result_src`=01.
- sw `0x00112223` with `mem_ready` low for 2 cycles in MEMWRITE:
  - Response: `imm_src`=001; `mem_write`=1 for exactly 3 cycles; then FETCH.
- beq, taken and not taken:
  - Stimulus: `op`=1100011, `zero`=1, then `zero`=0.
  - Response: `pc_write`=1 in BEQ only when `zero`=1; `alu_control`=001; `imm_src`=010.
- sub `0x40208033`:
  - Response: `alu_control`=001 in EXECUTER.
  - addi with `funct7b5`=1 (`op[5]`=0) gives `alu_control`=000.
- Unsupported opcode 0000000:
  - Macro defined: TRAP with `illegal_instr`=1 held for 10 cycles and no strobes.
  - Macro undefined: back in FETCH on the 3rd cycle.
